// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   ID/EX pipeline register with operand forwarding, sitting directly in front
//   of the ALU. It captures the decoded operands and control bits from ID, then
//   presents alu_a / alu_b / alu_ctl to the ALU one cycle later. Results still
//   in flight in EX/MEM and MEM/WB are forwarded combinationally. The stage also
//   flags load-use hazards to the hazard unit.
//
//   Slot qualification: ex_valid marks the EX slot as holding a real
//   instruction. Operands and forwards are produced whether or not the slot is
//   valid, so every consumer must qualify with ex_valid. There is no
//   backpressure handshake. The hazard unit sequences the stage with stall
//   (hold) and flush (bubble). If both arrive on the same edge, flush wins.
//
// Ports
//   clk, rst_n                     clock (rising edge) and async active-low reset
//   id_*                           decoded instruction fields from ID
//   stall, flush                   hold the ID/EX register / load a bubble
//   exmem_*, memwb_*               forwarding sources (write enable, rd, result)
//   alu_a, alu_b, alu_ctl          ALU operands and operation
//   ex_valid, ex_rd, ex_*          registered slot-valid, destination and control
//   ex_store_data                  forwarded rt value (SW data)
//   load_use_hazard                combinational load-use flag
// -----------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTL_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [15:0]       id_imm16,
   input  logic              id_imm_zext,
   input  logic              id_uses_rt,
   input  logic [CTL_W-1:0]  id_alu_ctl,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTL_W-1:0]  alu_ctl,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              load_use_hazard
);

   logic              ex_valid_q,      ex_valid_d;
   logic [REG_AW-1:0] ex_rs_q,         ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q,         ex_rt_d;
   logic [REG_AW-1:0] ex_rd_q,         ex_rd_d;
   logic [DATA_W-1:0] ex_rs_data_q,    ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q,    ex_rt_data_d;
   logic [DATA_W-1:0] ex_imm_q,        ex_imm_d;
   logic [CTL_W-1:0]  ex_alu_ctl_q,    ex_alu_ctl_d;
   logic              ex_alu_src_q,    ex_alu_src_d;
   logic              ex_reg_write_q,  ex_reg_write_d;
   logic              ex_mem_read_q,   ex_mem_read_d;
   logic              ex_mem_write_q,  ex_mem_write_d;
   logic              ex_mem_to_reg_q, ex_mem_to_reg_d;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic [DATA_W-1:0] id_ext_imm;

   // The immediate is extended once, at capture, so EX only ever sees a full-width value.
   always_comb begin
      id_ext_imm = '0;
      if (id_imm_zext) id_ext_imm = {{(DATA_W-16){1'b0}}, id_imm16};
      else             id_ext_imm = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
   end

   // EX/MEM is the younger result, so it takes priority over MEM/WB.
   // Register 0 is hard-wired to zero and is never forwarded.
   always_comb begin
      fwd_rs = ex_rs_data_q;
      if (exmem_reg_write && (exmem_rd == ex_rs_q) && (ex_rs_q != '0))
         fwd_rs = exmem_result;
      else if (memwb_reg_write && (memwb_rd == ex_rs_q) && (ex_rs_q != '0))
         fwd_rs = memwb_result;

      fwd_rt = ex_rt_data_q;
      if (exmem_reg_write && (exmem_rd == ex_rt_q) && (ex_rt_q != '0))
         fwd_rt = exmem_result;
      else if (memwb_reg_write && (memwb_rd == ex_rt_q) && (ex_rt_q != '0))
         fwd_rt = memwb_result;
   end

   always_comb begin
      ex_valid_d      = ex_valid_q;
      ex_rs_d         = ex_rs_q;
      ex_rt_d         = ex_rt_q;
      ex_rd_d         = ex_rd_q;
      ex_rs_data_d    = ex_rs_data_q;
      ex_rt_data_d    = ex_rt_data_q;
      ex_imm_d        = ex_imm_q;
      ex_alu_ctl_d    = ex_alu_ctl_q;
      ex_alu_src_d    = ex_alu_src_q;
      ex_reg_write_d  = ex_reg_write_q;
      ex_mem_read_d   = ex_mem_read_q;
      ex_mem_write_d  = ex_mem_write_q;
      ex_mem_to_reg_d = ex_mem_to_reg_q;
      if (flush) begin
         ex_valid_d      = 1'b0;
         ex_rs_d         = '0;
         ex_rt_d         = '0;
         ex_rd_d         = '0;
         ex_rs_data_d    = '0;
         ex_rt_data_d    = '0;
         ex_imm_d        = '0;
         ex_alu_ctl_d    = '0;
         ex_alu_src_d    = 1'b0;
         ex_reg_write_d  = 1'b0;
         ex_mem_read_d   = 1'b0;
         ex_mem_write_d  = 1'b0;
         ex_mem_to_reg_d = 1'b0;
      end else if (stall) begin
         // Absorb the currently forwarded values so a producer that retires
         // out of EX/MEM or MEM/WB during the stall is not lost.
         ex_rs_data_d = fwd_rs;
         ex_rt_data_d = fwd_rt;
      end else begin
         ex_valid_d      = id_valid;
         ex_rs_d         = id_rs;
         ex_rt_d         = id_rt;
         ex_rd_d         = id_rd;
         ex_rs_data_d    = id_rs_data;
         ex_rt_data_d    = id_rt_data;
         ex_imm_d        = id_ext_imm;
         ex_alu_ctl_d    = id_alu_ctl;
         ex_alu_src_d    = id_alu_src;
         ex_reg_write_d  = id_reg_write;
         ex_mem_read_d   = id_mem_read;
         ex_mem_write_d  = id_mem_write;
         ex_mem_to_reg_d = id_mem_to_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q      <= 1'b0;
         ex_rs_q         <= '0;
         ex_rt_q         <= '0;
         ex_rd_q         <= '0;
         ex_rs_data_q    <= '0;
         ex_rt_data_q    <= '0;
         ex_imm_q        <= '0;
         ex_alu_ctl_q    <= '0;
         ex_alu_src_q    <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         ex_mem_write_q  <= 1'b0;
         ex_mem_to_reg_q <= 1'b0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_rs_q         <= ex_rs_d;
         ex_rt_q         <= ex_rt_d;
         ex_rd_q         <= ex_rd_d;
         ex_rs_data_q    <= ex_rs_data_d;
         ex_rt_data_q    <= ex_rt_data_d;
         ex_imm_q        <= ex_imm_d;
         ex_alu_ctl_q    <= ex_alu_ctl_d;
         ex_alu_src_q    <= ex_alu_src_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         ex_mem_write_q  <= ex_mem_write_d;
         ex_mem_to_reg_q <= ex_mem_to_reg_d;
      end
   end

   assign alu_a         = fwd_rs;
   assign alu_b         = ex_alu_src_q ? ex_imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign alu_ctl       = ex_alu_ctl_q;
   assign ex_valid      = ex_valid_q;
   assign ex_rd         = ex_rd_q;
   assign ex_reg_write  = ex_reg_write_q;
   assign ex_mem_read   = ex_mem_read_q;
   assign ex_mem_write  = ex_mem_write_q;
   assign ex_mem_to_reg = ex_mem_to_reg_q;

   // A load in EX whose destination is read by the instruction in ID cannot
   // be forwarded in time; the hazard unit answers with a one-cycle bubble.
   assign load_use_hazard = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & id_valid &
                            ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));

endmodule
